// File: rtl/nand_read_sequencer.sv
// NAND page-read sequencer: 00h, four address cycles, 30h,
// ready/busy wait, then PAGE_BYTES data-out cycles on the shared bus.
module nand_read_sequencer #(
    parameter int PAGE_BYTES  = 2048,
    parameter int TWB_CYC     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        ce_n,
    output logic        cle,
    output logic        ale,
    output logic        we_n,
    output logic        re_n,
    output logic [7:0]  io_out,
    output logic        io_oe,
    input  logic [7:0]  io_in,
    input  logic        rb_n
);

    localparam int BW = $clog2(PAGE_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] LAST_B = BW'(PAGE_BYTES - 1);
    localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TWB_T  = TW'(TWB_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_WAIT,
        S_READ,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          ph_q, ph_d;
    logic [1:0]    aidx_q, aidx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          ce_n_q, ce_n_d;
    logic          cle_q, cle_d;
    logic          ale_q, ale_d;
    logic          we_n_q, we_n_d;
    logic          re_n_q, re_n_d;
    logic          io_oe_q, io_oe_d;
    logic [7:0]    io_out_q, io_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [1:0]    nidx;

    assign nidx = aidx_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= 1'b0;
            aidx_q     <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            addr_q     <= '0;
            ce_n_q     <= 1'b1;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            we_n_q     <= 1'b1;
            re_n_q     <= 1'b1;
            io_oe_q    <= 1'b0;
            io_out_q   <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            aidx_q     <= aidx_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
            addr_q     <= addr_d;
            ce_n_q     <= ce_n_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            we_n_q     <= we_n_d;
            re_n_q     <= re_n_d;
            io_oe_q    <= io_oe_d;
            io_out_q   <= io_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        aidx_d     = aidx_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        addr_d     = addr_q;
        ce_n_d     = ce_n_q;
        cle_d      = cle_q;
        ale_d      = ale_q;
        we_n_d     = we_n_q;
        re_n_d     = re_n_q;
        io_oe_d    = io_oe_q;
        io_out_d   = io_out_q;
        busy_d     = busy_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CMD1;
                    ph_d     = 1'b0;
                    addr_d   = addr;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    ce_n_d   = 1'b0;
                    cle_d    = 1'b1;
                    ale_d    = 1'b0;
                    we_n_d   = 1'b0;
                    io_oe_d  = 1'b1;
                    io_out_d = 8'h00;
                end
            end
            S_CMD1: begin
                ph_d = ~ph_q;
                if (!ph_q) begin
                    we_n_d = 1'b1;
                end else begin
                    state_d  = S_ADDR;
                    aidx_d   = 2'd0;
                    cle_d    = 1'b0;
                    ale_d    = 1'b1;
                    we_n_d   = 1'b0;
                    io_out_d = addr_q[7:0];
                end
            end
            S_ADDR: begin
                ph_d = ~ph_q;
                if (!ph_q) begin
                    we_n_d = 1'b1;
                end else if (aidx_q == 2'd3) begin
                    state_d  = S_CMD2;
                    ale_d    = 1'b0;
                    cle_d    = 1'b1;
                    we_n_d   = 1'b0;
                    io_out_d = 8'h30;
                end else begin
                    aidx_d   = nidx;
                    we_n_d   = 1'b0;
                    io_out_d = addr_q[{nidx, 3'b000} +: 8];
                end
            end
            S_CMD2: begin
                ph_d = ~ph_q;
                if (!ph_q) begin
                    we_n_d = 1'b1;
                end else begin
                    state_d  = S_WAIT;
                    cle_d    = 1'b0;
                    io_oe_d  = 1'b0;
                    io_out_d = 8'h00;
                    tcnt_d   = '0;
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                // ready wins over a timeout expiring on the same clock
                if (tcnt_q >= TWB_T && rb_n) begin
                    state_d = S_READ;
                    ph_d    = 1'b0;
                    bcnt_d  = '0;
                    re_n_d  = 1'b0;
                end else if (tcnt_q == LAST_T) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce_n_d  = 1'b1;
                end
            end
            S_READ: begin
                ph_d = ~ph_q;
                if (!ph_q) begin
                    rd_data_d  = io_in;
                    rd_valid_d = 1'b1;
                    re_n_d     = 1'b1;
                end else if (bcnt_q == LAST_B) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce_n_d  = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                    re_n_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                ph_d       = 1'b0;
                aidx_d     = '0;
                bcnt_d     = '0;
                tcnt_d     = '0;
                addr_d     = '0;
                ce_n_d     = 1'b1;
                cle_d      = 1'b0;
                ale_d      = 1'b0;
                we_n_d     = 1'b1;
                re_n_d     = 1'b1;
                io_oe_d    = 1'b0;
                io_out_d   = 8'h00;
                busy_d     = 1'b0;
                err_d      = 1'b0;
                rd_data_d  = 8'h00;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ce_n     = ce_n_q;
    assign cle      = cle_q;
    assign ale      = ale_q;
    assign we_n     = we_n_q;
    assign re_n     = re_n_q;
    assign io_out   = io_out_q;
    assign io_oe    = io_oe_q;

endmodule

// File: tb/tb_nand_read_sequencer.sv
// Scoreboard bench for nand_read_sequencer: bus cycles, read bytes
// and completion status are queued by stimulus and checked by a monitor.
module tb_nand_read_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        busy, done, error, rd_valid;
    logic [7:0]  rd_data, io_out, io_in;
    logic        ce_n, cle, ale, we_n, re_n, io_oe;
    logic        rb_n = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic       exp_dn[$];

    int cyc = 0;
    int wlow_cnt = 0;
    int rlow_cnt = 0;
    int done_cnt = 0;
    int cmd2_cyc = 0;
    int rv_cyc = 0;
    int rb_mode = 0;
    int rd_ref = 0;
    logic [7:0] rd_base = 8'h00;

    always #5 clk = ~clk;

    assign io_in = rd_base + 8'(rlow_cnt - rd_ref);

    nand_read_sequencer #(
        .PAGE_BYTES(4),
        .TWB_CYC(4),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
        .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n), .re_n(re_n),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .rb_n(rb_n)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        errors++;
        $display("FAIL %s act=unexpected exp=none t=%0t", nm, $time);
    endtask

    // device model: busy for 10 clocks after the 30h cycle
    logic mprev_we = 1'b1;
    int   bz = 0;
    always @(negedge clk) begin
        if (rb_mode == 1) begin
            rb_n = 1'b0;
        end else if (rb_mode == 2) begin
            rb_n = 1'b1;
        end else begin
            if (rst_n && !mprev_we && we_n && cle && io_out == 8'h30)
                bz = 10;
            else if (bz > 0)
                bz--;
            rb_n = (bz == 0);
        end
        mprev_we = rst_n ? we_n : 1'b1;
    end

    // monitor
    logic prev_we = 1'b1;
    logic prev_re = 1'b1;
    always @(negedge clk) begin
        logic [9:0] ew;
        logic [7:0] er;
        logic       ed;
        cyc++;
        if (!rst_n) begin
            prev_we = 1'b1;
            prev_re = 1'b1;
        end else begin
            if (prev_we && !we_n) wlow_cnt++;
            if (!prev_we && we_n) begin
                if (exp_wr.size() == 0) begin
                    miss("wr_cycle");
                end else begin
                    ew = exp_wr.pop_front();
                    chk("wr_byte", {22'h0, cle, ale, io_out}, {22'h0, ew});
                end
                if (cle && io_out == 8'h30) cmd2_cyc = cyc;
            end
            if (prev_re && !re_n) rlow_cnt++;
            if (rd_valid) begin
                rv_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    miss("rd_valid");
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_data", {24'h0, rd_data}, {24'h0, er});
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_dn.size() == 0) begin
                    miss("done");
                end else begin
                    ed = exp_dn.pop_front();
                    chk("done_err", {31'h0, error}, {31'h0, ed});
                    chk("done_bus", {30'h0, busy, ce_n}, 32'h1);
                    if (ed)
                        chk("to_gap", cyc - cmd2_cyc, 21);
                    else
                        chk("done_gap", cyc - rv_cyc, 1);
                end
            end
            prev_we = we_n;
            prev_re = re_n;
        end
    end

    function automatic logic [31:0] outs();
        return {12'h0, ce_n, cle, ale, we_n, re_n, io_oe, io_out,
                busy, done, error, rd_valid, rd_data};
    endfunction

    localparam logic [31:0] RST_OUTS = {12'h0, 6'b100110, 8'h00,
                                        4'b0000, 8'h00};

    task automatic run_op(input logic [31:0] a, input int mode,
                          input logic [7:0] base, input bit e_err,
                          input bit poke);
        int  w0, r0, d0;
        bit  p1, p2, got;
        w0 = wlow_cnt;
        r0 = rlow_cnt;
        d0 = done_cnt;
        p1 = 0;
        p2 = 0;
        got = 0;
        rb_mode = mode;
        rd_base = base;
        rd_ref = rlow_cnt + 1;
        exp_wr.push_back({2'b10, 8'h00});
        exp_wr.push_back({2'b01, a[7:0]});
        exp_wr.push_back({2'b01, a[15:8]});
        exp_wr.push_back({2'b01, a[23:16]});
        exp_wr.push_back({2'b01, a[31:24]});
        exp_wr.push_back({2'b10, 8'h30});
        if (!e_err)
            for (int i = 0; i < 4; i++)
                exp_rd.push_back(base + 8'(i));
        exp_dn.push_back(e_err);
        @(posedge clk);
        #1 start = 1'b1;
        addr = a;
        @(posedge clk);
        #1 start = 1'b0;
        addr = 32'hFFFF_FFFF;
        chk("busy_go", {30'h0, busy, error}, 32'h2);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            #1 start = 1'b0;
            if (done_cnt != d0) begin
                got = 1;
            end else if (poke) begin
                if (!p1 && wlow_cnt - w0 == 6 && !io_oe && re_n) begin
                    p1 = 1;
                    start = 1'b1;
                end else if (!p2 && !re_n) begin
                    p2 = 1;
                    start = 1'b1;
                end
            end
        end
        start = 1'b0;
        chk("op_done", {31'h0, got}, 32'h1);
        chk("we_pulses", wlow_cnt - w0, 6);
        chk("re_pulses", rlow_cnt - r0, e_err ? 0 : 4);
        repeat (12) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("q_empty", exp_wr.size() + exp_rd.size() + exp_dn.size(), 0);
        chk("idle_bus", {30'h0, ce_n, busy}, 32'h2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        #12;
        chk("reset_outs", outs(), RST_OUTS);
        @(negedge clk);
        rst_n = 1'b1;

        // abort mid-address with an async reset
        exp_wr.push_back({2'b10, 8'h00});
        exp_wr.push_back({2'b01, 8'h11});
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        addr = 32'h4433_2211;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("mid_addr", {29'h0, ale, we_n, io_out == 8'h22}, 32'h5);
        #1 rst_n = 1'b0;
        #1 chk("abort_outs", outs(), RST_OUTS);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_wr", exp_wr.size(), 0);

        run_op(32'h4433_2211, 0, 8'hA0, 1'b0, 1'b0);
        run_op(32'h8765_4321, 1, 8'h00, 1'b1, 1'b0);
        chk("err_held", {31'h0, error}, 32'h1);
        run_op(32'hDEAD_BEEF, 2, 8'hB0, 1'b0, 1'b0);
        run_op(32'h0A0B_0C0D, 0, 8'hC0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
